// File: rtl/invader_pkg.sv
// ============================================================================
// Module  : invader_pkg
// Brief   : Shared state encoding and default parameters for the march timer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package invader_pkg;

  localparam int DEF_N_INV     = 50;
  localparam int DEF_DELAY_W   = 4;
  localparam int DEF_SHIFT     = 0;
  localparam int DEF_MIN_DELAY = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_HALT  = 2'd3
  } march_state_e;

endpackage : invader_pkg

`default_nettype wire

// File: rtl/invader_popcount.sv
// ============================================================================
// Module  : invader_popcount
// Brief   : Combinational population count of the invader alive mask.
// Revision: 1.0
// ============================================================================
`default_nettype none

module invader_popcount
  import invader_pkg::*;
#(
  parameter int  N_INV = DEF_N_INV,
  localparam int CNT_W = $clog2(N_INV + 1)
) (
  input  logic [N_INV-1:0] invader_on,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N_INV; i++) begin
      count = count + CNT_W'(invader_on[i]);
    end
  end

endmodule : invader_popcount

`default_nettype wire

// File: rtl/invader_march_timer.sv
// ============================================================================
// Module  : invader_march_timer
// Brief   : Formation step pacing; fewer survivors give a shorter frame delay.
// Revision: 1.0
// ============================================================================
`default_nettype none

module invader_march_timer
  import invader_pkg::*;
#(
  parameter int  N_INV     = DEF_N_INV,
  parameter int  DELAY_W   = DEF_DELAY_W,
  parameter int  SHIFT     = DEF_SHIFT,
  parameter int  MIN_DELAY = DEF_MIN_DELAY,
  localparam int CNT_W     = $clog2(N_INV + 1)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic [1:0]         level,
  input  logic [N_INV-1:0]   invader_on,
  output logic               step,
  output logic [CNT_W-1:0]   alive_count,
  output logic [DELAY_W-1:0] delay,
  output logic               all_dead,
  output logic [1:0]         state
);

  localparam int CW = (CNT_W > DELAY_W) ? CNT_W : DELAY_W;
  localparam int DMAX_INT = (1 << DELAY_W) - 1;
  localparam int MIN_CLAMP = (MIN_DELAY > DMAX_INT) ? DMAX_INT : MIN_DELAY;
  localparam logic [DELAY_W-1:0] C_DMAX = '1;
  localparam logic [DELAY_W-1:0] C_MIN  = DELAY_W'(MIN_CLAMP);

  logic [CNT_W-1:0]   pop_w;
  logic [CNT_W-1:0]   alive_count_q;
  logic               all_dead_w;

  logic [CW-1:0]      shifted_w;
  logic [DELAY_W-1:0] raw_w;
  logic [DELAY_W-1:0] lvl_w;
  logic [DELAY_W-1:0] diff_w;
  logic [DELAY_W-1:0] target_w;

  march_state_e       state_q, state_d;
  logic [DELAY_W-1:0] fcnt_q, fcnt_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic               step_q, step_d;

  invader_popcount #(
    .N_INV (N_INV)
  ) u_popcount (
    .invader_on (invader_on),
    .count      (pop_w)
  );

  // all_dead follows the registered count so it lines up with the FSM's view.
  assign all_dead_w = (alive_count_q == '0);

  always_comb begin
    shifted_w = CW'(alive_count_q) >> SHIFT;
    raw_w     = (shifted_w > CW'(C_DMAX)) ? C_DMAX : shifted_w[DELAY_W-1:0];
    lvl_w     = DELAY_W'(level);
    diff_w    = (raw_w > lvl_w) ? (raw_w - lvl_w) : '0;
    target_w  = (diff_w < C_MIN) ? C_MIN : diff_w;
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    delay_d = delay_q;
    step_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!all_dead_w && enable) begin
          state_d = ST_RUN;
          fcnt_d  = '0;
          delay_d = target_w;
        end
      end
      ST_RUN: begin
        // Leaving RUN takes precedence, so a coincident frame_tick is dropped.
        if (all_dead_w) begin
          state_d = ST_HALT;
        end else if (!enable) begin
          state_d = ST_PAUSE;
        end else if (frame_tick) begin
          if (fcnt_q == delay_q) begin
            step_d  = 1'b1;
            fcnt_d  = '0;
            delay_d = target_w;
          end else begin
            fcnt_d = fcnt_q + DELAY_W'(1);
          end
        end
      end
      ST_PAUSE: begin
        if (all_dead_w) begin
          state_d = ST_HALT;
        end else if (enable) begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        if (!all_dead_w) begin
          state_d = ST_IDLE;
          fcnt_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      alive_count_q <= '0;
      state_q       <= ST_IDLE;
      fcnt_q        <= '0;
      delay_q       <= '0;
      step_q        <= 1'b0;
    end else begin
      alive_count_q <= pop_w;
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      delay_q       <= delay_d;
      step_q        <= step_d;
    end
  end

  assign step        = step_q;
  assign alive_count = alive_count_q;
  assign delay       = delay_q;
  assign all_dead    = all_dead_w;
  assign state       = state_q;

endmodule : invader_march_timer

`default_nettype wire

// File: doc/invader_march_timer.md
INVADER_MARCH_TIMER -- requirements
Module: invader_march_timer

Interface
REQ-001 SHALL have parameter N_INV, default 50: number of invader slots.
REQ-002 SHALL have parameter DELAY_W, default 4: delay width; max delay DMAX = 2^DELAY_W-1.
REQ-003 SHALL have parameter SHIFT, default 0: alive count right-shifted by SHIFT before saturation.
REQ-004 SHALL have parameter MIN_DELAY, default 0: floor applied after level bias.
REQ-005 SHALL have localparam CNT_W = $clog2(N_INV+1).
REQ-006 SHALL have ports, clock and reset first (one clock; reset synchronous, active-high):
- Clk  in  1  system clock
- Reset  in  1  synchronous active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- enable  in  1  march allowed; low = pause
- level  in  2  speed bias subtracted from delay
- invader_on  in  N_INV  alive mask, bit i = invader i alive
- step  out  1  one-cycle pulse, advance formation one step
- alive_count  out  CNT_W  registered population count
- delay  out  DELAY_W  currently latched frames-per-step
- all_dead  out  1  alive_count == 0
- state  out  2  FSM state encoding

Function
REQ-007 SHALL register alive_count = popcount(invader_on) every cycle; latency 1 cycle.
REQ-008 SHALL compute raw = min(alive_count >> SHIFT, DMAX), then target = max(raw - level, MIN_DELAY); subtraction must not wrap below zero.
REQ-009 SHALL latch delay <= target only at period start: entry to RUN and cycle of each step; no change mid-period.
REQ-010 SHALL hold a frame counter fcnt (DELAY_W bits) counting frame_tick pulses in RUN.
REQ-011 SHALL, on frame_tick in RUN with fcnt == delay, assert step next cycle for exactly 1 cycle, clear fcnt, relatch delay; else increment fcnt.
REQ-012 SHALL, with delay == 0, assert step once per frame_tick.
REQ-013 SHALL implement FSM states IDLE=0, RUN=1, PAUSE=2, HALT=3.
REQ-014 SHALL transition IDLE->RUN when enable=1 and all_dead=0; fcnt cleared, delay latched.
REQ-015 SHALL transition RUN->PAUSE when enable=0; fcnt held; PAUSE->RUN when enable=1, fcnt and delay retained.
REQ-016 SHALL transition RUN or PAUSE->HALT when all_dead=1; step never asserted in HALT, IDLE or PAUSE.
REQ-017 SHALL transition HALT->IDLE when all_dead=0 (new wave); fcnt cleared.
REQ-018 SHALL give all_dead priority over enable when both change in one cycle.
REQ-019 SHALL ignore frame_tick in any cycle the FSM leaves RUN.
REQ-020 SHALL derive all_dead from registered alive_count, not raw mask.

Reset
REQ-021 SHALL, on Reset=1 at Clk edge, set state=IDLE, fcnt=0, step=0, delay=0, alive_count=0, all_dead=1; Reset overrides frame_tick and enable.
REQ-022 SHALL, on Reset mid-period, discard fcnt; no step emitted in the cycle after reset.

Structure
REQ-023 SHALL place FSM state enum and default parameter constants in shared package invader_pkg.
REQ-024 SHALL implement popcount as sub-module invader_popcount (parameter N_INV, combinational, output CNT_W), registered in parent.

Verification
REQ-025 All 50 alive, level=0, enable=1: delay=15, step every 16th frame_tick, exactly 1 cycle wide.
REQ-026 Mask drops to 3 alive mid-period: delay stays 15 until next step, then delay=3, step every 4th frame_tick.
REQ-027 7 alive, level=3, MIN_DELAY=0: delay=4; 2 alive, level=3: delay=0, step every frame_tick.
REQ-028 enable low after 5 frame_ticks of period: no step, fcnt=5 held; enable high: step after 11 further ticks (delay 15).
REQ-029 Mask cleared to 0: all_dead=1 after 1 cycle, state=HALT, no step; mask refilled: HALT->IDLE->RUN, fcnt=0.
REQ-030 Reset asserted coincident with frame_tick at fcnt==delay: no step, all outputs at REQ-021 values next cycle.
